// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Detects load-use hazards (one-cycle stall with a bubble) and optionally
// bypasses a same-cycle register-file write into the captured operands.
// Optional feature macro: ID_EX_WB_BYPASS_EN (write-back bypass into ex_op_a/ex_op_b).
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_op,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [3:0]        alu_op;
    } ex_reg_t;

    ex_reg_t           ex_q, ex_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              load_use;
    logic [DATA_W-1:0] op_a_sel, op_b_sel;

    // Load-use hazard: load in EX whose destination the decode slot sources.
    always_comb begin
        load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_q.dest)) |
                    (id_uses_rt & (id_rt == ex_q.dest)));
        stall = load_use & ~flush;
    end

`ifdef ID_EX_WB_BYPASS_EN
    // Register file writes at the edge but reads combinationally, so a
    // same-cycle write to a source register must be picked up here. r0 never is.
    always_comb begin
        op_a_sel = id_read_data1;
        op_b_sel = id_read_data2;
        if (wb_reg_write && (wb_rd == id_rs) && (id_rs != 5'd0)) op_a_sel = wb_write_data;
        if (wb_reg_write && (wb_rd == id_rt) && (id_rt != 5'd0)) op_b_sel = wb_write_data;
    end
`else
    logic unused_wb;
    // Without the bypass the write-back port is ignored; operands pass straight through.
    always_comb begin
        unused_wb = ^{wb_reg_write, wb_rd, wb_write_data};
        op_a_sel  = id_read_data1;
        op_b_sel  = id_read_data2;
    end
`endif

    // Next EX contents: bubble on flush or stall, else capture decode; control gated by id_valid.
    always_comb begin
        ex_d = '0;
        if (!flush && !stall) begin
            ex_d.valid      = id_valid;
            ex_d.pc_plus4   = id_pc_plus4;
            ex_d.op_a       = op_a_sel;
            ex_d.op_b       = op_b_sel;
            ex_d.imm        = id_imm;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.dest       = id_reg_dst ? id_rd : id_rt;
            ex_d.reg_write  = id_reg_write  & id_valid;
            ex_d.mem_read   = id_mem_read   & id_valid;
            ex_d.mem_write  = id_mem_write  & id_valid;
            ex_d.mem_to_reg = id_mem_to_reg & id_valid;
            ex_d.alu_src    = id_alu_src    & id_valid;
            ex_d.alu_op     = id_valid ? id_alu_op : 4'd0;
        end
    end

    // Saturating count of stall cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + 1'b1;
    end

    // Pipeline and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc_plus4   = ex_q.pc_plus4;
    assign ex_op_a       = ex_q.op_a;
    assign ex_op_b       = ex_q.op_b;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_alu_op     = ex_q.alu_op;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use stall, flush
// priority, write-back bypass, counter saturation (second instance, CNT_W=4).
module tb_id_ex_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, id_valid, id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm, wb_write_data;
    logic [4:0]    id_rs, id_rt, id_rd, wb_rd;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]    id_alu_op;
    logic          wb_reg_write, flush;

    logic          stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [DW-1:0] ex_pc_plus4, ex_op_a, ex_op_b, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_dest;
    logic [3:0]    ex_alu_op;
    logic [15:0]   stall_count;

    logic          stall4, ex_valid4, ex_reg_write4, ex_mem_read4, ex_mem_write4, ex_mem_to_reg4, ex_alu_src4;
    logic [DW-1:0] ex_pc_plus44, ex_op_a4, ex_op_b4, ex_imm4;
    logic [4:0]    ex_rs4, ex_rt4, ex_dest4;
    logic [3:0]    ex_alu_op4;
    logic [3:0]    stall_count4;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_write_data(wb_write_data), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_pc_plus4(ex_pc_plus4), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .stall_count(stall_count)
    );

    id_ex_stage #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_write_data(wb_write_data), .flush(flush), .stall(stall4), .ex_valid(ex_valid4),
        .ex_pc_plus4(ex_pc_plus44), .ex_op_a(ex_op_a4), .ex_op_b(ex_op_b4), .ex_imm(ex_imm4),
        .ex_rs(ex_rs4), .ex_rt(ex_rt4), .ex_dest(ex_dest4), .ex_reg_write(ex_reg_write4),
        .ex_mem_read(ex_mem_read4), .ex_mem_write(ex_mem_write4), .ex_mem_to_reg(ex_mem_to_reg4),
        .ex_alu_src(ex_alu_src4), .ex_alu_op(ex_alu_op4), .stall_count(stall_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc_plus4 = '0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_read_data1 = '0; id_read_data2 = '0; id_imm = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_alu_src = 0; id_reg_dst = 0;
        id_alu_op = 4'd0; wb_reg_write = 0; wb_rd = 0; wb_write_data = '0; flush = 0;
    endtask

    // lw $rt, imm($rs): destination is rt
    task automatic set_load(input logic [4:0] rs, input logic [4:0] rt);
        clear_id();
        id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = 1; id_reg_dst = 0;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_alu_op = 4'h2;
    endtask

    // R-type: rd <= rs op rt
    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        clear_id();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_reg_dst = 1;
        id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1; id_alu_op = 4'h2;
        id_read_data1 = d1; id_read_data2 = d2;
    endtask

    initial begin
        // Reset held two cycles with random inputs
        clear_id();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
            id_read_data1 = $urandom; id_read_data2 = $urandom; id_imm = $urandom;
            id_mem_read = 1'($urandom); id_reg_write = 1'($urandom); id_uses_rs = 1'($urandom);
            tick();
        end
        chk("rst_valid", ex_valid, 0);
        chk("rst_op_a", ex_op_a, 0);
        chk("rst_op_b", ex_op_b, 0);
        chk("rst_dest", ex_dest, 0);
        chk("rst_memrd", ex_mem_read, 0);
        chk("rst_regwr", ex_reg_write, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_stall", stall, 0);
        reset = 0;

        // Plain capture
        set_rtype(5'd3, 5'd4, 5'd5, 32'h11, 32'h22);
        id_pc_plus4 = 32'h104; id_imm = 32'h7;
        tick();
        chk("cap_valid", ex_valid, 1);
        chk("cap_op_a", ex_op_a, 32'h11);
        chk("cap_op_b", ex_op_b, 32'h22);
        chk("cap_dest", ex_dest, 5);
        chk("cap_pc", ex_pc_plus4, 32'h104);
        chk("cap_imm", ex_imm, 32'h7);
        chk("cap_rs_rt", {ex_rs, ex_rt}, {5'd3, 5'd4});
        chk("cap_ctrl", {ex_reg_write, ex_mem_read, ex_alu_op}, {1'b1, 1'b0, 4'h2});

        // Load into r8, then a consumer of r8
        set_load(5'd2, 5'd8);
        #1 chk("lw_nostall", stall, 0);
        tick();
        chk("lw_dest", ex_dest, 8);
        chk("lw_memrd", ex_mem_read, 1);
        set_rtype(5'd8, 5'd9, 5'd10, 32'h55, 32'h66);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("bub_valid", ex_valid, 0);
        chk("bub_ctrl", {ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_alu_op}, 0);
        chk("bub_dest", ex_dest, 0);
        chk("bub_op_a", ex_op_a, 0);
        chk("lu_cnt", stall_count, 1);
        chk("lu_stall_off", stall, 0);
        tick();
        chk("held_valid", ex_valid, 1);
        chk("held_dest", ex_dest, 10);
        chk("held_op_a", ex_op_a, 32'h55);
        chk("held_cnt", stall_count, 1);

        // Load into r0 never causes a hazard
        set_load(5'd1, 5'd0);
        tick();
        set_rtype(5'd0, 5'd0, 5'd6, 32'h0, 32'h0);
        #1 chk("r0_nostall", stall, 0);

        // Consumer via rt also stalls
        set_load(5'd1, 5'd7);
        tick();
        set_rtype(5'd1, 5'd7, 5'd6, 32'h1, 32'h2);
        #1 chk("rt_stall", stall, 1);
        tick();
        chk("rt_cnt", stall_count, 2);
        tick();

        // Flush wins over hazard
        set_load(5'd2, 5'd8);
        tick();
        set_rtype(5'd8, 5'd9, 5'd10, 32'h55, 32'h66);
        flush = 1;
        #1 chk("fl_stall", stall, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_cnt", stall_count, 2);

        // Write-back bypass
        set_rtype(5'd0, 5'd4, 5'd5, 32'h77, 32'h0);
        wb_reg_write = 1; wb_rd = 5'd4; wb_write_data = 32'hDEADBEEF;
        tick();
`ifdef ID_EX_WB_BYPASS_EN
        chk("byp_op_b", ex_op_b, 32'hDEADBEEF);
`else
        chk("byp_op_b", ex_op_b, 32'h0);
`endif
        chk("byp_op_a", ex_op_a, 32'h77);
        set_rtype(5'd0, 5'd0, 5'd5, 32'h33, 32'h0);
        wb_reg_write = 1; wb_rd = 5'd0; wb_write_data = 32'hDEADBEEF;
        tick();
        chk("byp_r0_b", ex_op_b, 32'h0);
        chk("byp_r0_a", ex_op_a, 32'h33);

        // lw r8,(r8) repeatedly: stalls every other edge, 20 stalls over 40 edges
        set_load(5'd8, 5'd8);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_cnt16", stall_count, 22);
        chk("sat_cnt4", stall_count4, 15);

        // Mid-stream reset
        reset = 1;
        tick();
        chk("mrst_cnt16", stall_count, 0);
        chk("mrst_cnt4", stall_count4, 0);
        chk("mrst_valid", ex_valid, 0);
        chk("mrst_stall", stall, 0);
        reset = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage MIPS core. It captures decoded operands from the register file plus the decode control word, and presents them to Execute one cycle later. It detects load-use hazards, inserting one bubble and raising `stall` to hold PC and IF/ID. It also bypasses a same-cycle write-back into the captured operands, because the register file writes on the clock edge but reads combinationally.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `CNT_W`, 16, width of the stall performance counter

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous active-high reset
- `id_valid`  in  1  decode slot holds a real instruction
- `id_pc_plus4`  in  DATA_W  PC+4 of decoded instruction
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register specifiers
- `id_read_data1`, `id_read_data2`  in  DATA_W  register-file read ports for rs/rt
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction actually sources rs/rt
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src`, `id_reg_dst`  in  1 each  decode control
- `id_alu_op`  in  4  ALU operation
- `wb_reg_write`  in  1  write-back enable (same net driving the register file)
- `wb_rd`  in  5  write-back destination
- `wb_write_data`  in  DATA_W  write-back data
- `flush`  in  1  branch/jump resolved taken in EX; kill decode slot
- `stall`  out  1  hold PC and IF/ID this cycle (combinational)
- `ex_valid`  out  1  EX slot holds a real instruction
- `ex_pc_plus4`, `ex_op_a`, `ex_op_b`, `ex_imm`  out  DATA_W  latched values
- `ex_rs`, `ex_rt`  out  5  latched specifiers (for forwarding unit)
- `ex_dest`  out  5  resolved destination: `id_rd` if `id_reg_dst`, else `id_rt`
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_alu_src`  out  1 each  latched control
- `ex_alu_op`  out  4  latched ALU op
- `stall_count`  out  CNT_W  saturating count of stall cycles

## Operation
- Hazard condition H = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_dest`≠0) & ((`id_uses_rs` & `id_rs`==`ex_dest`) | (`id_uses_rt` & `id_rt`==`ex_dest`)).
- `stall` = H & ~`flush`.
- Register update priority at each posedge:
  1. `reset`: all outputs cleared.
  2. `flush`: load a bubble.
  3. `stall`: load a bubble.
  4. Otherwise: capture ID inputs, with `ex_valid` = `id_valid`.
- Bubble: `ex_valid`, all control outputs and `ex_dest` = 0; data fields cleared to 0.
- When `ex_valid`=0, control outputs are 0, so a bubble never writes registers or memory.
- Operand capture: `ex_op_a` = bypass(`id_rs`, `id_read_data1`) and `ex_op_b` = bypass(`id_rt`, `id_read_data2`).
- bypass(r, d) = `wb_write_data` if `wb_reg_write` & `wb_rd`==r & r≠0; otherwise d.
- Register 0 is never bypassed.
- `stall_count` increments by 1 on each cycle `stall`=1, saturates at all-ones, and is cleared only by `reset`.

## Timing
- Latency: ID inputs appear on `ex_*` one cycle after the capturing edge.
- `stall` depends on the current `ex_*` state and current ID inputs only, with no clock delay. It contains no path from `wb_*`.
- A load-use hazard yields exactly one stall cycle: after the bubble, `ex_mem_read`=0 and H deasserts. The held instruction is captured on the following edge.
- Simultaneous `flush` and H: `stall`=0, bubble loaded, `stall_count` unchanged.
- Simultaneous write-back and read of the same non-zero register: the captured operand equals `wb_write_data`.
- `reset` asserted mid-stream: next edge clears all outputs including `stall_count`. `stall` is 0 while `ex_valid`=0.
- Reset values: all outputs 0.

## Configuration
- `ID_EX_WB_BYPASS_EN` defined: write-back bypass as described.
- `ID_EX_WB_BYPASS_EN` undefined: `ex_op_a`/`ex_op_b` capture `id_read_data1`/`id_read_data2` unmodified. The `wb_*` ports remain but are unused. The integration must then ensure a write-to-read separation of at least one cycle, or handle it with forwarding.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> all outputs 0, `stall`=0.
- Plain capture: `id_valid`=1, rs=3, rt=4, rd=5, `id_reg_dst`=1, data1=0x11, data2=0x22 -> next cycle `ex_op_a`=0x11, `ex_op_b`=0x22, `ex_dest`=5, `ex_valid`=1.
- Load-use: EX holds lw with `ex_dest`=8; ID has rs=8, `id_uses_rs`=1 -> `stall`=1 for exactly one cycle, bubble in EX, ID instruction captured next edge, `stall_count`=1.
- Flush priority: same hazard plus `flush`=1 -> `stall`=0, next `ex_valid`=0, `stall_count` unchanged.
- WB bypass (macro on): `wb_reg_write`=1, `wb_rd`=4, data 0xDEADBEEF; ID rt=4, data2=0 -> `ex_op_b`=0xDEADBEEF. With `wb_rd`=0 and rt=0 -> `ex_op_b`=0.
- Counter saturation: with `CNT_W`=4, force 20 consecutive stalls -> `stall_count`=15.
